grf_wport_arb: RTL
==================

Name: grf_wport_arb

Overview:
- Arbitrates the single register-file write port (WE/A3/WD/PC) between two requesters:
  - the main pipeline writeback stage, which has fixed priority and is never stalled;
  - the multi-cycle multiply/divide unit result path, which uses a valid/ready handshake.
- Buffers MDU results in a small FIFO.
- Keeps a 32-bit pending-write scoreboard that the hazard unit uses for RAW/WAW stalls.
- Sits between the writeback/MDU stages and grf; its outputs drive grf's write port directly.

Parameters:
- DEPTH, 2, number of MDU result buffer entries (power of two, >=2).

Ports:
- CLK  in  1  system clock; state updates on posedge (grf writes on negedge of the same cycle).
- Reset  in  1  asynchronous, active-high reset.
- wb_we  in  1  pipeline writeback request.
- wb_a3  in  5  pipeline destination register.
- wb_wd  in  32  pipeline write data.
- wb_pc  in  32  PC of the pipeline writing instruction.
- md_valid  in  1  MDU result valid.
- md_ready  out  1  buffer can accept an MDU result.
- md_a3  in  5  MDU destination register.
- md_wd  in  32  MDU result data.
- md_pc  in  32  PC of the MDU instruction.
- md_issue  in  1  MDU instruction issued this cycle.
- md_issue_a3  in  5  destination register of the issued MDU instruction.
- grf_we  out  1  to grf WE.
- grf_a3  out  5  to grf A3.
- grf_wd  out  32  to grf WD.
- grf_pc  out  32  to grf PC.
- busy  out  32  scoreboard; bit r=1 means a write to $r is pending from the MDU.

Behaviour:
- Reset (async, Reset=1):
  - FIFO is empty (count=0, pointers 0); all squash bits are cleared; busy=0.
  - grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0.
  - md_ready is forced 0 while Reset is high; it is 1 from the first cycle after deassertion.
- Reset mid-operation: queued results are discarded and never written.
- Handshake:
  - md_ready = (count < DEPTH), registered-count based; no same-cycle pop-frees-slot bypass.
  - A transfer occurs on a posedge with md_valid && md_ready.
  - md_valid must hold until the transfer.
  - A transfer with md_a3==0 completes but is not enqueued.
- Port selection (combinational from current state and inputs):
  - If wb_we && wb_a3!=0: outputs = wb_*, grf_we=1. The FIFO does not pop.
  - Else if FIFO is not empty: outputs = head entry, grf_we = !head.squash. The head pops at posedge.
  - Else: grf_we=0, and a3/wd/pc are 0.
  - wb_we with wb_a3==0 is treated as no request, and the FIFO may drain that cycle.
- Latency:
  - An MDU result accepted at posedge N is written at the earliest in cycle N+1 (grf negedge).
  - Each consecutive pipeline write delays it by one cycle.
  - There is no bypass from md_* straight to grf.
- Ordering:
  - The FIFO drains strictly in order.
  - Simultaneous push and pop are allowed whenever count < DEPTH before the edge.
- Squash (WAW safety):
  - When the pipeline writes wb_a3=r (r!=0), every queued entry with a3==r gets squash=1 at that posedge.
  - An incoming MDU result pushed in the same cycle with md_a3==r is also enqueued squashed.
  - A squashed entry still takes one drain cycle, with grf_we=0.
- Scoreboard:
  - busy[r] is set at posedge when md_issue && md_issue_a3==r && r!=0.
  - busy[r] is cleared at the posedge where an entry with a3==r pops, whether written or squashed.
  - Set and clear of the same r in one cycle: set wins.
  - busy[0] is always 0.
  - busy is registered (visible the cycle after the edge).

Decomposition:
- Package grf_pkg holds:
  - REG_AW=5 and DATA_W=32;
  - the wport_entry_t struct {squash, a3[4:0], wd[31:0], pc[31:0]}.
- One sub-module, wport_fifo:
  - parameterised DEPTH;
  - push/pop/head/count;
  - a per-entry squash-by-address input.
- Arbitration and the scoreboard stay in the top module.

Test Plan:
- Reset then idle:
  - After reset: md_ready=1, busy=0, grf_we=0 every cycle.
  - Assert Reset mid-run with 2 entries queued: grf_we stays 0 afterward.
- MDU alone:
  - Stimulus: md_issue a3=5; two cycles later push wd=0x12345678, pc=0x3010.
  - Required: next cycle grf_we=1, a3=5, wd=0x12345678, pc=0x3010.
  - busy[5] goes 1 → 0 one cycle after the write.
- Pipeline priority:
  - Stimulus: wb_we held 3 cycles with a3=1,2,3 while one MDU entry for $8 is queued.
  - Required: writes go out in order $1,$2,$3,$8.
  - md_ready drops to 0 after a second push (DEPTH=2) and returns to 1 on the $8 drain.
- Squash:
  - Stimulus: queue an MDU result for $9; pipeline writes $9=0xAAAA0000 before the drain.
  - Required: the drain cycle has grf_we=0, the final $9=0xAAAA0000, and busy[9] clears.
- $0 handling:
  - MDU push with md_a3=0 completes the handshake, enqueues nothing, and produces no write.
  - md_issue_a3=0 leaves busy=0.
  - wb_we with a3=0 lets the FIFO head drain that cycle.
- Set/clear collision:
  - Stimulus: md_issue a3=4 in the same cycle an entry for $4 pops.
  - Required: busy[4] remains 1.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared widths and the buffered write-port entry format for the register-file
// write-port arbiter.
package grf_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              squash;
        logic [REG_AW-1:0] a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wport_entry_t;

endpackage

// File: rtl/wport_fifo.sv
// In-order buffer for MDU results waiting on the register-file write port,
// with per-entry squash-by-address so stale results never overwrite newer data.
module wport_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wport_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       squash_en,
    input  logic [REG_AW-1:0]          squash_a3,
    output wport_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wport_entry_t        entries [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    // A push in the same cycle as a squash writes after the squash loop, so the
    // incoming entry carries its own squash bit computed by the arbiter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (squash_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].a3 == squash_a3) begin
                        entries[i].squash <= 1'b1;
                    end
                end
            end
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = entries[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/grf_wport_arb.sv
// Register-file write-port arbiter: the pipeline writeback has fixed priority,
// MDU results queue in a FIFO, and a pending-write scoreboard feeds the hazard unit.
module grf_wport_arb
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_a3,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_a3,
    input  logic [DATA_W-1:0] md_wd,
    input  logic [DATA_W-1:0] md_pc,
    input  logic              md_issue,
    input  logic [REG_AW-1:0] md_issue_a3,
    output logic              grf_we,
    output logic [REG_AW-1:0] grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    output logic [31:0]       busy
);

    localparam int CW = $clog2(DEPTH+1);

    logic                wb_sel;
    logic                md_xfer;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    wport_entry_t        push_entry;
    wport_entry_t        head;
    logic [31:0]         busy_next;

    // A writeback to $0 is no request at all, which lets the FIFO drain that cycle.
    assign wb_sel    = wb_we && (wb_a3 != '0);
    assign md_ready  = !Reset && (fifo_count < CW'(DEPTH));
    assign md_xfer   = md_valid && md_ready;
    assign fifo_push = md_xfer && (md_a3 != '0);
    assign fifo_pop  = !wb_sel && !fifo_empty;

    always_comb begin
        push_entry        = '0;
        push_entry.squash = wb_sel && (md_a3 == wb_a3);
        push_entry.a3     = md_a3;
        push_entry.wd     = md_wd;
        push_entry.pc     = md_pc;
    end

    wport_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (Reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .squash_en  (wb_sel),
        .squash_a3  (wb_a3),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    // Port mux; a squashed head still occupies its drain cycle with WE low.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (!Reset) begin
            if (wb_sel) begin
                grf_we = 1'b1;
                grf_a3 = wb_a3;
                grf_wd = wb_wd;
                grf_pc = wb_pc;
            end else if (!fifo_empty) begin
                grf_we = !head.squash;
                grf_a3 = head.a3;
                grf_wd = head.wd;
                grf_pc = head.pc;
            end
        end
    end

    // Issue sets after the pop clears so a same-register collision stays busy.
    always_comb begin
        busy_next = busy;
        if (fifo_pop) begin
            busy_next[head.a3] = 1'b0;
        end
        if (md_issue && (md_issue_a3 != '0)) begin
            busy_next[md_issue_a3] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule
